// File: rtl/uart_pkg.sv
// Shared UART constants, the transmitter state type and a parity helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } tx_state_e;

    // Callers zero-extend narrower words, so the extra bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [8:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with first-word fall-through read data.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Push,
    input  logic [WIDTH-1:0]       i_Data,
    input  logic                   i_Pop,
    output logic [WIDTH-1:0]       o_Data,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_Full  = (count_q == FullCount);
    assign o_Empty = (count_q == '0);
    assign o_Count = count_q;
    assign o_Data  = mem_q[rd_ptr_q];
    assign push_ok = i_Push & ~o_Full;
    assign pop_ok  = i_Pop & ~o_Empty;

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok != pop_ok) begin
                count_q <= push_ok ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames go out LSB-first with no idle gap between them.
// Define UART_TX_BREAK_EN to add the i_Break input and the line-break state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_Break,
`endif
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LastClk  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LastStop = 4'(STOP_BITS - 1);

    tx_state_e              state_q;
    logic [CW-1:0]          clk_cnt_q;
    logic [3:0]             bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   serial_q;
    logic                   active_q;
    logic                   done_q;
    logic                   overflow_q;

    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   stop_end;
    logic                   break_req;
    logic                   rel_end;

`ifdef UART_TX_BREAK_EN
    logic brk_rel_q;
    assign break_req = i_Break;
    assign rel_end   = (state_q == StBreak) & brk_rel_q & bit_end;
`else
    assign break_req = 1'b0;
    assign rel_end   = 1'b0;
`endif

    assign bit_end  = (clk_cnt_q == LastClk);
    assign stop_end = (state_q == StStop) & bit_end & (bit_idx_q == LastStop);
    assign push     = i_Tx_DV & ~fifo_full;

    // A pending break wins over the queue at every frame boundary.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !break_req) begin
            pop = (state_q == StIdle) | stop_end | rel_end;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (push),
        .i_Data  (i_Tx_Byte),
        .i_Pop   (pop),
        .o_Data  (fifo_rdata),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty),
        .o_Count (o_Fifo_Count)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= StIdle;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_rel_q  <= 1'b0;
`endif
        end else begin
            done_q     <= stop_end;
            overflow_q <= i_Tx_DV & fifo_full;
            if (pop) begin
                state_q   <= StStart;
                clk_cnt_q <= '0;
                shift_q   <= fifo_rdata;
                parity_q  <= calc_parity(9'(fifo_rdata), PARITY_MODE);
                serial_q  <= 1'b0;
                active_q  <= 1'b1;
`ifdef UART_TX_BREAK_EN
                brk_rel_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (break_req) begin
                            state_q  <= StBreak;
                            serial_q <= 1'b0;
                        end
                    end
                    StStart, StData: begin
                        if (!bit_end) begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end else begin
                            clk_cnt_q <= '0;
                            if (state_q == StStart || bit_idx_q != LastData) begin
                                state_q   <= StData;
                                bit_idx_q <= (state_q == StStart) ? 4'd0 : bit_idx_q + 4'd1;
                                serial_q  <= shift_q[0];
                                shift_q   <= shift_q >> 1;
                            end else if (PARITY_MODE != PARITY_NONE) begin
                                state_q  <= StParity;
                                serial_q <= parity_q;
                            end else begin
                                state_q   <= StStop;
                                bit_idx_q <= '0;
                                serial_q  <= 1'b1;
                            end
                        end
                    end
                    StParity: begin
                        if (!bit_end) begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end else begin
                            clk_cnt_q <= '0;
                            state_q   <= StStop;
                            bit_idx_q <= '0;
                            serial_q  <= 1'b1;
                        end
                    end
                    StStop: begin
                        if (!bit_end) begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end else begin
                            clk_cnt_q <= '0;
                            if (bit_idx_q == LastStop) begin
                                state_q  <= break_req ? StBreak : StIdle;
                                serial_q <= ~break_req;
                                active_q <= 1'b0;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                            end
                        end
                    end
`ifdef UART_TX_BREAK_EN
                    // Hold the line low while requested, then one idle-high bit time.
                    StBreak: begin
                        if (!brk_rel_q) begin
                            clk_cnt_q <= '0;
                            if (!break_req) begin
                                brk_rel_q <= 1'b1;
                                serial_q  <= 1'b1;
                            end
                        end else if (bit_end) begin
                            brk_rel_q <= 1'b0;
                            clk_cnt_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                        end
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_Tx_Ready  = ~fifo_full;
    assign o_Overflow  = overflow_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scheduled writes are replayed through a frame-level queue model.
// Define UART_TX_BREAK_EN to include the break scenario.
module tb_uart_tx_fifo;
    localparam int NCYC  = 600;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv1, dv3;
    logic [7:0] byte1;
    logic [6:0] byte3;
    logic       rdy1, ovf1, act1, ser1, done1;
    logic       rdy3, ovf3, act3, ser3, done3;
    logic [2:0] cnt1, cnt3;
`ifdef UART_TX_BREAK_EN
    logic       brk;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit         sch_dv   [NCYC];
    logic [8:0] sch_data [NCYC];
    bit         exp_ser  [NCYC];
    bit         exp_act  [NCYC];
    bit         exp_done [NCYC];
    bit         exp_ovf  [NCYC];
    bit         exp_rdy  [NCYC];
    int         exp_cnt  [NCYC];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY_MODE (2), .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_Clock (clk), .i_Reset (rst), .i_Tx_DV (dv1), .i_Tx_Byte (byte1),
`ifdef UART_TX_BREAK_EN
        .i_Break (brk),
`endif
        .o_Tx_Ready (rdy1), .o_Overflow (ovf1), .o_Fifo_Count (cnt1),
        .o_Tx_Active (act1), .o_Tx_Serial (ser1), .o_Tx_Done (done1)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY_MODE (1), .STOP_BITS (2), .FIFO_DEPTH (DEPTH)
    ) dut3 (
        .i_Clock (clk), .i_Reset (rst), .i_Tx_DV (dv3), .i_Tx_Byte (byte3),
`ifdef UART_TX_BREAK_EN
        .i_Break (1'b0),
`endif
        .o_Tx_Ready (rdy3), .o_Overflow (ovf3), .o_Fifo_Count (cnt3),
        .o_Tx_Active (act3), .o_Tx_Serial (ser3), .o_Tx_Done (done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic void clear_exp();
        for (int c = 0; c < NCYC; c++) begin
            exp_ser[c] = 1'b1; exp_act[c] = 1'b0; exp_done[c] = 1'b0;
            exp_ovf[c] = 1'b0; exp_rdy[c] = 1'b1; exp_cnt[c] = 0;
        end
    endfunction

    function automatic void clear_sched();
        for (int c = 0; c < NCYC; c++) begin
            sch_dv[c] = 1'b0; sch_data[c] = '0;
        end
    endfunction

    function automatic int frame_len(int dbits, int pmode, int sbits);
        return CPB * (1 + dbits + ((pmode != 0) ? 1 : 0) + sbits);
    endfunction

    // Line waveform of one frame whose start bit begins at cycle 'start'.
    function automatic void place_frame(int start, logic [8:0] w, int dbits, int pmode, int sbits);
        bit b[$];
        bit p;
        p = 1'b0;
        b.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            b.push_back(w[i]);
            p ^= w[i];
        end
        if (pmode == 1) b.push_back(!p);
        else if (pmode == 2) b.push_back(p);
        for (int i = 0; i < sbits; i++) b.push_back(1'b1);
        for (int k = 0; k < b.size() * CPB; k++) begin
            if (start + k < NCYC) begin
                exp_ser[start + k] = b[k / CPB];
                exp_act[start + k] = 1'b1;
            end
        end
        if (start + b.size() * CPB < NCYC) exp_done[start + b.size() * CPB] = 1'b1;
    endfunction

    // Queue model: a write lands if fewer than DEPTH words were held at the start of the cycle;
    // a held word is taken once the previous frame reaches its final cycle, and goes out next cycle.
    function automatic void build_model(int dbits, int pmode, int sbits);
        logic [8:0] q[$];
        int  cnt, free_at;
        bit  acc, pp;
        cnt = 0; free_at = 0;
        clear_exp();
        for (int c = 0; c < NCYC; c++) begin
            exp_cnt[c] = cnt;
            exp_rdy[c] = (cnt < DEPTH);
            pp  = (cnt > 0) && (c >= free_at);
            acc = sch_dv[c] && (cnt < DEPTH);
            if (sch_dv[c] && !acc && c + 1 < NCYC) exp_ovf[c + 1] = 1'b1;
            if (pp) begin
                place_frame(c + 1, q.pop_front(), dbits, pmode, sbits);
                free_at = c + frame_len(dbits, pmode, sbits);
            end
            if (acc) q.push_back(sch_data[c]);
            cnt = cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
        end
    endfunction

    task automatic reset_dut();
        rst = 1'b1; dv1 = 1'b0; dv3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sched(input bit sel, input int ncyc);
        reset_dut();
        for (int c = 0; c < ncyc; c++) begin
            cyc = c;
            if (!sel) begin
                chk("serial", ser1, exp_ser[c]);  chk("active", act1, exp_act[c]);
                chk("done", done1, exp_done[c]);  chk("overflow", ovf1, exp_ovf[c]);
                chk("ready", rdy1, exp_rdy[c]);   chk("count", cnt1, exp_cnt[c]);
                dv1 = sch_dv[c]; byte1 = sch_data[c][7:0];
            end else begin
                chk("serial3", ser3, exp_ser[c]); chk("active3", act3, exp_act[c]);
                chk("done3", done3, exp_done[c]); chk("overflow3", ovf3, exp_ovf[c]);
                chk("ready3", rdy3, exp_rdy[c]);  chk("count3", cnt3, exp_cnt[c]);
                dv3 = sch_dv[c]; byte3 = sch_data[c][6:0];
            end
            @(negedge clk);
        end
        cyc = ncyc;
        dv1 = 1'b0; dv3 = 1'b0;
    endtask

    initial begin
        logic [8:0] w0, w1;
        rst = 1'b1; dv1 = 1'b0; dv3 = 1'b0; byte1 = '0; byte3 = '0;
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        // Single 0xA5 into an idle block.
        clear_sched(); sch_dv[0] = 1'b1; sch_data[0] = 9'h0A5;
        build_model(8, 2, 1); run_sched(1'b0, 60);

        // Six consecutive writes: five accepted, one overflow, frames back to back.
        clear_sched();
        for (int c = 0; c < 6; c++) begin
            sch_dv[c] = 1'b1; sch_data[c] = 9'($urandom_range(0, 255));
        end
        build_model(8, 2, 1); run_sched(1'b0, 240);

        // Write while full in the same cycle the FIFO pops: rejected.
        clear_sched();
        for (int c = 0; c < 5; c++) begin
            sch_dv[c] = 1'b1; sch_data[c] = 9'($urandom_range(0, 255));
        end
        sch_dv[45] = 1'b1; sch_data[45] = 9'h1FF & 9'h0FF;
        build_model(8, 2, 1); run_sched(1'b0, 240);

        // Random sparse writes with one burst.
        clear_sched();
        for (int c = 0; c < 520; c++) begin
            sch_dv[c]   = ($urandom_range(0, 15) == 0) || (c >= 200 && c < 210);
            sch_data[c] = 9'($urandom_range(0, 255));
        end
        build_model(8, 2, 1); run_sched(1'b0, 580);

        // Odd parity, 7 data bits, 2 stop bits, all-zero word.
        clear_sched(); sch_dv[0] = 1'b1; sch_data[0] = 9'h000;
        build_model(7, 1, 2); run_sched(1'b1, 60);

        clear_sched();
        for (int c = 0; c < 400; c++) begin
            sch_dv[c]   = ($urandom_range(0, 9) == 0);
            sch_data[c] = 9'($urandom_range(0, 127));
        end
        build_model(7, 1, 2); run_sched(1'b1, 480);

        // Reset during data bit 3 with two words queued.
        clear_sched();
        for (int c = 0; c < 3; c++) begin
            sch_dv[c] = 1'b1; sch_data[c] = 9'($urandom_range(0, 255));
        end
        build_model(8, 2, 1); run_sched(1'b0, 19);
        chk("mid_bit3", ser1, exp_ser[19]);
        chk("mid_count", cnt1, 2);
        rst = 1'b1;
        @(negedge clk);
        cyc = 20;
        chk("rst_serial", ser1, 1'b1); chk("rst_active", act1, 1'b0);
        chk("rst_count", cnt1, 0);     chk("rst_ready", rdy1, 1'b1);
        rst = 1'b0;
        for (int c = 21; c < 170; c++) begin
            @(negedge clk);
            cyc = c;
            chk("post_rst_serial", ser1, 1'b1);
            chk("post_rst_active", act1, 1'b0);
            chk("post_rst_done", done1, 1'b0);
        end

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame, released at cycle 60; queued word follows one bit later.
        w0 = 9'($urandom_range(0, 255)); w1 = 9'($urandom_range(0, 255));
        clear_exp();
        place_frame(2, w0, 8, 2, 1);
        for (int c = 46; c <= 60; c++) exp_ser[c] = 1'b0;
        place_frame(65, w1, 8, 2, 1);
        reset_dut();
        for (int c = 0; c < 130; c++) begin
            cyc = c;
            chk("brk_serial", ser1, exp_ser[c]);
            chk("brk_active", act1, exp_act[c]);
            chk("brk_done", done1, exp_done[c]);
            if (c == 64) chk("brk_count_held", cnt1, 1);
            if (c == 65) chk("brk_count_pop", cnt1, 0);
            dv1   = (c < 2);
            byte1 = (c == 0) ? w0[7:0] : w1[7:0];
            brk   = (c >= 10 && c < 60);
            @(negedge clk);
        end
        dv1 = 1'b0; brk = 1'b0;
`else
        w0 = '0; w1 = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
